uart_tx_feeder: RTL and testbench
=================================

// Module: uart_tx_feeder
// PURPOSE
//  Byte buffer and handshake controller placed directly upstream of the UART Tx serializer.
//  Accepts result bytes from the MPU datapath/ALU, queues them in a small synchronous FIFO,
//  and hands them one at a time to the serializer: drives tx data + a 1-cycle tx_en strobe,
//  then waits for the serializer's completion pulse before issuing the next byte.
// PARAMETERS
//  DEPTH   8   FIFO depth in bytes; power of two, >= 2
//  AW      3   FIFO pointer width, log2(DEPTH)
// PORTS
//  clk            in   1  system clock; one clock domain, all logic on posedge
//  rst            in   1  reset; synchronous, active-high
//  i_wr_d         in   8  byte to queue
//  i_wr_en        in   1  write strobe; accepted only when o_full==0
//  o_full         out  1  FIFO holds DEPTH bytes
//  o_empty        out  1  FIFO holds 0 bytes
//  o_overflow     out  1  sticky: a write arrived while o_full==1
//  o_busy         out  1  FSM not in IDLE (byte in flight)
//  o_tx_d         out  8  byte presented to the serializer
//  o_tx_en        out  1  1-cycle start strobe to the serializer
//  i_tx_complete  in   1  1-cycle pulse from the serializer after the stop bit
// BEHAVIOUR
//  Reset (synchronous, rst==1 at posedge):
//   - FIFO pointers and count = 0; o_empty = 1; o_full = 0; o_overflow = 0.
//   - State = IDLE; o_tx_d = 8'h00; o_tx_en = 0; o_busy = 0.
//   - Mid-transfer reset drops the in-flight byte and all queued bytes. The serializer shares
//     this reset, so no completion pulse is expected afterwards.
//  FIFO:
//   - Write when i_wr_en && !o_full; count increments next cycle.
//   - Write while full: data discarded and o_overflow set; it stays set until reset.
//   - Pop only on the IDLE->LOAD transition. A push and a pop in the same cycle leave count
//     unchanged. No bypass: a byte written into an empty FIFO is visible to the FSM 1 cycle later.
//   - Pointers wrap modulo DEPTH. o_full and o_empty are decoded from the registered count.
//  FSM (3 states):
//   - IDLE: if !o_empty, pop head into o_tx_d -> LOAD; else stay.
//   - LOAD: o_tx_en = 1 for exactly this cycle -> WAIT.
//   - WAIT: hold o_tx_d stable; on i_tx_complete -> IDLE.
//   - i_tx_complete in IDLE or LOAD is ignored (spurious). There is no timeout.
//  Timing:
//   - Latency: write at cycle N into an empty idle block -> o_tx_en high at cycle N+2.
//   - Back-to-back: completion at cycle M -> next o_tx_en at M+2 (one IDLE cycle between bytes).
//   - o_busy = (state != IDLE). o_tx_d changes only on the IDLE->LOAD transition.
// STRUCTURE
//  - Shared include/package: FSM state encodings (IDLE=2'd0, LOAD=2'd1, WAIT=2'd2) and the
//    default DEPTH/AW values.
//  - Sub-module sync_fifo (DEPTH, AW, 8-bit): wr_en, rd_en, din, dout, full, empty, count.
//  - The top level holds the FSM, the o_tx_d register and the overflow flag.
// TESTING
//  1. Assert rst for 2 cycles mid-WAIT with 3 bytes queued -> next cycle o_empty=1, o_busy=0,
//     o_tx_en=0, o_tx_d=8'h00; no further o_tx_en.
//  2. Write 8'hA5 at cycle N -> o_tx_en=1 only at N+2 with o_tx_d=8'hA5; o_tx_d holds
//     8'hA5 until completion.
//  3. Write 8'h01,8'h02,8'h03 on consecutive cycles; model completes each byte 20 cycles after
//     o_tx_en -> three strobes in order 01,02,03; each strobe 2 cycles after the previous completion.
//  4. Fill with 8 bytes while the serializer is stalled -> o_full=1. A 9th write (8'hFF) sets
//     o_overflow and is not sent; after draining, exactly 8 bytes are sent.
//  5. At full, write coincident with the IDLE->LOAD pop -> write rejected (o_full registered),
//     o_overflow=1, count stays 7 after the pop.
//  6. Pulse i_tx_complete while IDLE with an empty FIFO, then write 8'h3C -> pulse ignored;
//     8'h3C is sent normally and WAIT waits for a fresh completion pulse.

Source files
------------

// File: rtl/uart_tx_feeder_pkg.sv
// Shared definitions for the UART Tx feeder: FSM state encoding and default FIFO geometry.
package uart_tx_feeder_pkg;

    localparam int DEPTH_DEF = 8;
    localparam int AW_DEF    = 3;
    localparam int DATA_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2
    } tx_state_t;

endpackage

// File: rtl/uart_tx_feeder_sync_fifo.sv
// Single-clock show-ahead byte FIFO; the head entry is always visible on dout,
// and full/empty are decoded from the registered occupancy count.
module uart_tx_feeder_sync_fifo
    import uart_tx_feeder_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       count
);

    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              wr_ok;
    logic              rd_ok;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;
    assign dout  = mem[rd_ptr];

    // Storage carries no reset; validity is tracked entirely by count.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte buffer and handshake controller ahead of the UART Tx serializer: queues bytes,
// issues one tx_en strobe per byte and waits for the serializer's completion pulse.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | nothing in flight; pops the FIFO head when a byte is queued
// LOAD  | o_tx_d just loaded; o_tx_en high for this single cycle
// WAIT  | serializer busy; o_tx_d held until i_tx_complete
module uart_tx_feeder
    import uart_tx_feeder_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_wr_d,
    input  logic              i_wr_en,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_overflow,
    output logic              o_busy,
    output logic [DATA_W-1:0] o_tx_d,
    output logic              o_tx_en,
    input  logic              i_tx_complete
);

    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    tx_state_t         state;
    tx_state_t         next_state;
    logic              pop;
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic [AW:0]       fifo_count;

    uart_tx_feeder_sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (i_wr_en),
        .rd_en (pop),
        .din   (i_wr_d),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Completion pulses outside WAIT are spurious and simply fall through the default hold.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    next_state = ST_LOAD;
                end
            end
            ST_LOAD: next_state = ST_WAIT;
            ST_WAIT: begin
                if (i_tx_complete) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // o_tx_d only moves on the IDLE->LOAD pop, so it is stable for the whole transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_tx_d <= '0;
        end else if (pop) begin
            o_tx_d <= fifo_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_overflow <= 1'b0;
        end else if (i_wr_en && fifo_full) begin
            o_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (fifo_count <= FULL_CNT);
        end
    end

    assign o_full  = fifo_full;
    assign o_empty = fifo_empty;
    assign o_tx_en = (state == ST_LOAD);
    assign o_busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: hand-timed writes and completion pulses with
// cycle-exact expected strobes, data and flags.
module tb_uart_tx_feeder;

    logic       clk;
    logic       rst;
    logic [7:0] i_wr_d;
    logic       i_wr_en;
    logic       o_full;
    logic       o_empty;
    logic       o_overflow;
    logic       o_busy;
    logic [7:0] o_tx_d;
    logic       o_tx_en;
    logic       i_tx_complete;

    int total = 0;
    int bad   = 0;

    uart_tx_feeder dut (
        .clk           (clk),
        .rst           (rst),
        .i_wr_d        (i_wr_d),
        .i_wr_en       (i_wr_en),
        .o_full        (o_full),
        .o_empty       (o_empty),
        .o_overflow    (o_overflow),
        .o_busy        (o_busy),
        .o_tx_d        (o_tx_d),
        .o_tx_en       (o_tx_en),
        .i_tx_complete (i_tx_complete)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Step past the next rising edge; inputs are driven and outputs sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] d);
        i_wr_d  = d;
        i_wr_en = 1'b1;
        tick();
        i_wr_en = 1'b0;
    endtask

    task automatic pulse_complete();
        i_tx_complete = 1'b1;
        tick();
        i_tx_complete = 1'b0;
    endtask

    // Wait dly cycles, complete the current byte, expect the next strobe 2 cycles later.
    task automatic serve(input int dly, input logic [7:0] exp, input string tag);
        repeat (dly) tick();
        pulse_complete();
        chk({tag, "_gap_en"}, o_tx_en, 1'b0);
        chk({tag, "_gap_busy"}, o_busy, 1'b0);
        tick();
        chk({tag, "_en"}, o_tx_en, 1'b1);
        chk({tag, "_d"}, o_tx_d, exp);
    endtask

    task automatic expect_quiet(input int n, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (o_tx_en) seen = 1'b1;
        end
        chk({tag, "_no_strobe"}, seen, 1'b0);
        chk({tag, "_busy"}, o_busy, 1'b0);
        chk({tag, "_empty"}, o_empty, 1'b1);
    endtask

    initial begin
        rst           = 1'b1;
        i_wr_d        = 8'h00;
        i_wr_en       = 1'b0;
        i_tx_complete = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_empty", o_empty, 1'b1);
        chk("rst_full", o_full, 1'b0);
        chk("rst_ovf", o_overflow, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_en", o_tx_en, 1'b0);
        chk("rst_d", o_tx_d, 8'h00);

        // Single byte: write at N, strobe in N+2, data held through WAIT.
        write_byte(8'hA5);
        chk("lat_n1_en", o_tx_en, 1'b0);
        tick();
        chk("lat_n2_en", o_tx_en, 1'b1);
        chk("lat_n2_d", o_tx_d, 8'hA5);
        tick();
        chk("lat_load_1cyc", o_tx_en, 1'b0);
        repeat (5) tick();
        chk("lat_hold_d", o_tx_d, 8'hA5);
        chk("lat_hold_busy", o_busy, 1'b1);
        pulse_complete();
        chk("lat_done_busy", o_busy, 1'b0);
        expect_quiet(4, "lat");

        // Three consecutive writes, serializer completes 20 cycles after each strobe.
        i_wr_en = 1'b1;
        i_wr_d  = 8'h01;
        tick();
        i_wr_d  = 8'h02;
        tick();
        i_wr_d  = 8'h03;
        chk("b2b_first_en", o_tx_en, 1'b1);
        chk("b2b_first_d", o_tx_d, 8'h01);
        tick();
        i_wr_en = 1'b0;
        serve(19, 8'h02, "b2b_02");
        serve(20, 8'h03, "b2b_03");
        repeat (20) tick();
        pulse_complete();
        expect_quiet(5, "b2b_end");

        // Spurious completions in IDLE and LOAD are ignored.
        pulse_complete();
        chk("spur_idle_busy", o_busy, 1'b0);
        chk("spur_idle_en", o_tx_en, 1'b0);
        write_byte(8'h3C);
        tick();
        chk("spur_en", o_tx_en, 1'b1);
        chk("spur_d", o_tx_d, 8'h3C);
        pulse_complete();
        chk("spur_load_busy", o_busy, 1'b1);
        repeat (10) tick();
        chk("spur_wait_busy", o_busy, 1'b1);
        chk("spur_wait_d", o_tx_d, 8'h3C);
        pulse_complete();
        expect_quiet(4, "spur_end");

        // Fill 8 bytes behind a stalled transfer, then overflow with 8'hFF.
        write_byte(8'h50);
        tick();
        chk("fill_head_d", o_tx_d, 8'h50);
        for (int i = 0; i < 8; i++) write_byte(8'h10 + 8'(i));
        chk("fill_full", o_full, 1'b1);
        chk("fill_empty", o_empty, 1'b0);
        chk("fill_ovf_pre", o_overflow, 1'b0);
        write_byte(8'hFF);
        chk("fill_ovf", o_overflow, 1'b1);
        chk("fill_full_post", o_full, 1'b1);
        for (int i = 0; i < 8; i++) serve(3, 8'h10 + 8'(i), $sformatf("drain_%0d", i));
        repeat (3) tick();
        pulse_complete();
        expect_quiet(10, "drain_end");
        chk("drain_last_d", o_tx_d, 8'h17);
        chk("drain_ovf_sticky", o_overflow, 1'b1);

        // Reset mid-WAIT with three bytes queued drops everything.
        write_byte(8'h61);
        tick();
        write_byte(8'h71);
        write_byte(8'h72);
        write_byte(8'h73);
        repeat (2) tick();
        chk("mrst_pre_busy", o_busy, 1'b1);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("mrst_empty", o_empty, 1'b1);
        chk("mrst_busy", o_busy, 1'b0);
        chk("mrst_en", o_tx_en, 1'b0);
        chk("mrst_d", o_tx_d, 8'h00);
        chk("mrst_ovf", o_overflow, 1'b0);
        expect_quiet(10, "mrst");

        // Write while full coincident with the IDLE->LOAD pop is rejected.
        write_byte(8'h80);
        tick();
        for (int i = 0; i < 8; i++) write_byte(8'h81 + 8'(i));
        repeat (2) tick();
        pulse_complete();
        chk("pop_full_pre", o_full, 1'b1);
        i_wr_d  = 8'hEE;
        i_wr_en = 1'b1;
        tick();
        i_wr_en = 1'b0;
        chk("pop_en", o_tx_en, 1'b1);
        chk("pop_d", o_tx_d, 8'h81);
        chk("pop_count", 32'(dut.fifo_count), 32'd7);
        chk("pop_ovf", o_overflow, 1'b1);
        chk("pop_full_post", o_full, 1'b0);
        for (int i = 0; i < 7; i++) serve(3, 8'h82 + 8'(i), $sformatf("pop_drain_%0d", i));
        repeat (3) tick();
        pulse_complete();
        expect_quiet(10, "pop_end");
        chk("pop_last_d", o_tx_d, 8'h88);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
